// File: rtl/ts_ep3_in_packer_if.sv
// Byte-stream input and EP3 buf_in port bundle for the TS packer.
// master: the packer; slave: the TS source plus the EP3 buffer side.
interface ts_ep3_in_packer_if;
    logic [7:0]  ts_data;
    logic        ts_valid;
    logic        ts_sync;
    logic        ts_ready;
    logic [10:0] buf_in_addr;
    logic [7:0]  buf_in_data;
    logic        buf_in_wren;
    logic        buf_in_ready;
    logic        buf_in_commit;
    logic [10:0] buf_in_commit_len;
    logic        buf_in_commit_ack;
    logic [15:0] stat_xfer_cnt;
    logic        stat_sync_err;

    modport master (
        input  ts_data, ts_valid, ts_sync, buf_in_ready, buf_in_commit_ack,
        output ts_ready, buf_in_addr, buf_in_data, buf_in_wren,
               buf_in_commit, buf_in_commit_len, stat_xfer_cnt, stat_sync_err
    );

    modport slave (
        output ts_data, ts_valid, ts_sync, buf_in_ready, buf_in_commit_ack,
        input  ts_ready, buf_in_addr, buf_in_data, buf_in_wren,
               buf_in_commit, buf_in_commit_len, stat_xfer_cnt, stat_sync_err
    );
endinterface

// File: rtl/ts_ep3_in_packer.sv
// Packs a byte-serial MPEG-TS stream into the EP3 bulk IN buffer, committing
// full transfers of XFER_LEN bytes or a partial transfer after an idle timeout.
module ts_ep3_in_packer #(
    parameter int unsigned XFER_LEN     = 512,
    parameter int unsigned FLUSH_CYCLES = 65535
) (
    input logic                ext_clk,
    input logic                reset_n,
    ts_ep3_in_packer_if.master bus
);
    localparam logic [10:0] FULL_LEN  = 11'(XFER_LEN);
    localparam logic [16:0] FLUSH_LIM = 17'(FLUSH_CYCLES);
    localparam logic [7:0]  PKT_LAST  = 8'd187;

    typedef enum logic [1:0] {WAIT_RDY, FILL, COMMIT, ACK_LOW} state_t;
    state_t state, state_next;

    logic [10:0] fill_cnt;
    logic [15:0] idle_cnt;
    logic [7:0]  pkt_cnt;
    logic        aligned;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        sync_err;
    logic [15:0] xfer_cnt;

    logic ready, accept, write, idle, flush_due;

    always_comb begin
        ready     = (state == FILL) && (fill_cnt != FULL_LEN);
        accept    = ready && bus.ts_valid;
        write     = accept && (aligned || bus.ts_sync);
        idle      = (state == FILL) && !accept && (fill_cnt != '0);
        // Expiry is judged on the count including this idle cycle, so an
        // accepted byte in the same cycle always pre-empts the flush.
        flush_due = idle && (({1'b0, idle_cnt} + 17'd1) >= FLUSH_LIM);
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_RDY: if (bus.buf_in_ready && !bus.buf_in_commit_ack) state_next = FILL;
            FILL:     if ((fill_cnt == FULL_LEN) || flush_due) state_next = COMMIT;
            COMMIT:   if (bus.buf_in_commit_ack) state_next = ACK_LOW;
            ACK_LOW:  if (!bus.buf_in_commit_ack) state_next = WAIT_RDY;
            default:  state_next = WAIT_RDY;
        endcase
    end

    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= WAIT_RDY;
            fill_cnt <= '0;
            idle_cnt <= '0;
            pkt_cnt  <= '0;
            aligned  <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_en    <= 1'b0;
            sync_err <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            state    <= state_next;
            wr_en    <= write;
            sync_err <= write && bus.ts_sync && (pkt_cnt != '0);

            if (state == WAIT_RDY) begin
                fill_cnt <= '0;
            end else if (write) begin
                fill_cnt <= fill_cnt + 11'd1;
            end

            if (write) begin
                wr_addr <= fill_cnt;
                wr_data <= bus.ts_data;
                aligned <= 1'b1;
                if (bus.ts_sync) begin
                    pkt_cnt <= 8'd1;
                end else if (pkt_cnt == PKT_LAST) begin
                    pkt_cnt <= '0;
                end else begin
                    pkt_cnt <= pkt_cnt + 8'd1;
                end
            end

            if (accept || (state != FILL)) begin
                idle_cnt <= '0;
            end else if (idle) begin
                idle_cnt <= idle_cnt + 16'd1;
            end

            if ((state == COMMIT) && bus.buf_in_commit_ack) begin
                xfer_cnt <= xfer_cnt + 16'd1;
            end
        end
    end

    assign bus.ts_ready          = ready;
    assign bus.buf_in_addr       = wr_addr;
    assign bus.buf_in_data       = wr_data;
    assign bus.buf_in_wren       = wr_en;
    assign bus.buf_in_commit     = (state == COMMIT);
    assign bus.buf_in_commit_len = (state == COMMIT) ? fill_cnt : '0;
    assign bus.stat_xfer_cnt     = xfer_cnt;
    assign bus.stat_sync_err     = sync_err;
endmodule

// File: tb/tb_ts_ep3_in_packer.sv
// Randomized scoreboard bench for ts_ep3_in_packer: a queue-based stream model
// predicts buffer writes and commits, a monitor compares what the DUT emits.
module tb_ts_ep3_in_packer;
    localparam int unsigned XFER  = 376;
    localparam int unsigned FLUSH = 100;

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  data;
        logic        err;
    } wr_t;

    typedef struct {
        logic [10:0] len;
        int unsigned at;
    } cm_t;

    logic ext_clk = 1'b0;
    logic reset_n = 1'b0;

    ts_ep3_in_packer_if ifc();

    ts_ep3_in_packer #(.XFER_LEN(XFER), .FLUSH_CYCLES(FLUSH)) dut (
        .ext_clk(ext_clk),
        .reset_n(reset_n),
        .bus    (ifc)
    );

    always #5 ext_clk = ~ext_clk;

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned cyc = 0;
    wr_t wq[$];
    cm_t cq[$];

    // Stream model: alignment flag, position within a 188-byte packet, bytes buffered.
    bit          m_aligned = 0;
    int unsigned m_pkt = 0;
    int unsigned m_fill = 0;
    int unsigned last_acc = 0;
    int unsigned exp_xfer = 0;
    bit          gap_en = 1;
    bit          ack_slow = 0;
    bit          resp_busy = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [49:0] outvec();
        return {ifc.ts_ready, ifc.buf_in_addr, ifc.buf_in_data, ifc.buf_in_wren, ifc.buf_in_commit,
                ifc.buf_in_commit_len, ifc.stat_xfer_cnt, ifc.stat_sync_err};
    endfunction

    function automatic void model_accept(input logic [7:0] d, input logic s, input int unsigned c);
        wr_t w;
        cm_t m;
        last_acc = c;
        if (!(s || m_aligned)) return;
        w.addr = 11'(m_fill);
        w.data = d;
        w.err  = s && (m_pkt != 0);
        wq.push_back(w);
        m_aligned = 1;
        m_pkt = s ? 1 : (m_pkt + 1) % 188;
        m_fill++;
        if (m_fill == XFER) begin
            m.len = 11'(XFER);
            m.at  = c + 2;
            cq.push_back(m);
            m_fill = 0;
        end
    endfunction

    function automatic void model_reset();
        m_aligned = 0;
        m_pkt = 0;
        m_fill = 0;
        exp_xfer = 0;
    endfunction

    initial forever begin
        @(posedge ext_clk);
        cyc++;
    end

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] d, input logic s);
        int unsigned waited = 0;
        bit done = 0;
        bit rdy;
        int unsigned c;
        if (gap_en && ($urandom_range(0, 7) == 0)) begin
            ifc.ts_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge ext_clk);
        end
        ifc.ts_data  = d;
        ifc.ts_sync  = s;
        ifc.ts_valid = 1'b1;
        while (!done) begin
            rdy = ifc.ts_ready;
            c = cyc;
            @(posedge ext_clk);
            if (rdy) begin
                done = 1;
                model_accept(d, s, c);
            end else if (++waited > 2000) begin
                done = 1;
                chk("ready_timeout", 64'(waited), 64'(0));
            end
            @(negedge ext_clk);
        end
        ifc.ts_valid = 1'b0;
        ifc.ts_sync  = 1'b0;
    endtask

    task automatic send_pkt(input int unsigned n);
        send_byte(8'h47, 1'b1);
        for (int unsigned i = 1; i < n; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic send_junk(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic idle(input int unsigned n);
        cm_t m;
        ifc.ts_valid = 1'b0;
        ifc.ts_sync  = 1'b0;
        if ((n >= FLUSH) && (m_fill != 0)) begin
            m.len = 11'(m_fill);
            m.at  = last_acc + FLUSH + 1;
            cq.push_back(m);
            m_fill = 0;
        end
        repeat (n) @(negedge ext_clk);
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        ifc.ts_valid = 1'b0;
        while ((wq.size() != 0 || cq.size() != 0 || ifc.buf_in_commit || resp_busy) && n < 3000) begin
            @(negedge ext_clk);
            n++;
        end
        chk({tag, "_drained"}, 64'(n < 3000), 64'(1));
        chk({tag, "_xfer_cnt"}, 64'(ifc.stat_xfer_cnt), 64'(exp_xfer));
    endtask

    // Monitor: writes, sync-error pulses, commit rises.
    initial begin
        bit  prev_commit = 0;
        wr_t w;
        cm_t m;
        forever begin
            @(negedge ext_clk);
            if (!reset_n) begin
                prev_commit = 0;
            end else begin
                if (ifc.buf_in_wren) begin
                    chk("wren_expected", 64'(wq.size() != 0), 64'(1));
                    if (wq.size() != 0) begin
                        w = wq.pop_front();
                        chk("wr_addr", 64'(ifc.buf_in_addr), 64'(w.addr));
                        chk("wr_data", 64'(ifc.buf_in_data), 64'(w.data));
                        chk("sync_err", 64'(ifc.stat_sync_err), 64'(w.err));
                    end
                end else begin
                    chk("sync_err_without_write", 64'(ifc.stat_sync_err), 64'(0));
                end
                if (ifc.buf_in_commit) chk("commit_with_wren", 64'(ifc.buf_in_wren), 64'(0));
                if (ifc.buf_in_commit && !prev_commit) begin
                    chk("commit_expected", 64'(cq.size() != 0), 64'(1));
                    if (cq.size() != 0) begin
                        m = cq.pop_front();
                        chk("commit_len", 64'(ifc.buf_in_commit_len), 64'(m.len));
                        chk("commit_cycle", 64'(cyc), 64'(m.at));
                    end
                end
                prev_commit = ifc.buf_in_commit;
            end
        end
    end

    // Ack responder, also checks the hold, drop and re-fill timing of the handshake.
    initial begin
        int unsigned dly, hold;
        logic [10:0] len0;
        bit bad;
        ifc.buf_in_commit_ack = 1'b0;
        forever begin
            @(negedge ext_clk);
            if (reset_n && ifc.buf_in_commit) begin
                resp_busy = 1;
                dly  = ack_slow ? 200 : $urandom_range(0, 5);
                hold = ack_slow ? 10 : $urandom_range(1, 4);
                len0 = ifc.buf_in_commit_len;
                bad  = 0;
                repeat (dly) begin
                    @(negedge ext_clk);
                    if (!ifc.buf_in_commit || ifc.buf_in_commit_len != len0 || ifc.ts_ready) bad = 1;
                end
                chk("commit_hold_stable", 64'(bad), 64'(0));
                ifc.buf_in_commit_ack = 1'b1;
                @(negedge ext_clk);
                chk("commit_drop_after_ack", 64'(ifc.buf_in_commit), 64'(0));
                exp_xfer++;
                bad = 0;
                repeat (hold) begin
                    @(negedge ext_clk);
                    if (ifc.ts_ready || ifc.buf_in_wren || ifc.buf_in_commit) bad = 1;
                end
                chk("no_refill_while_ack", 64'(bad), 64'(0));
                ifc.buf_in_commit_ack = 1'b0;
                @(negedge ext_clk);
                chk("ready_low_k1", 64'(ifc.ts_ready), 64'(0));
                @(negedge ext_clk);
                chk("ready_high_k2", 64'(ifc.ts_ready), 64'(1));
                resp_busy = 0;
            end
        end
    end

    initial begin
        ifc.ts_data      = '0;
        ifc.ts_valid     = 1'b0;
        ifc.ts_sync      = 1'b0;
        ifc.buf_in_ready = 1'b1;

        repeat (3) @(negedge ext_clk);
        chk("reset_outputs", 64'(outvec()), 64'(0));
        reset_n = 1'b1;
        @(negedge ext_clk);

        // Pre-sync discard followed by a full 376-byte transfer.
        send_junk(10);
        send_pkt(188);
        send_pkt(188);
        drain("full_commit");

        // Idle flush of one packet.
        send_pkt(188);
        idle(FLUSH + 20);
        drain("flush");

        // Byte arriving on the cycle the idle count would expire wins.
        gap_en = 0;
        send_pkt(94);
        idle(FLUSH - 1);
        send_junk(94);
        idle(FLUSH);
        gap_en = 1;
        drain("flush_boundary");

        // Early sync mid-packet, then clean packets across a commit boundary.
        send_pkt(50);
        send_pkt(188);
        send_pkt(188);
        send_pkt(188);
        idle(FLUSH + 5);
        drain("sync_err");

        // Slow acknowledge.
        ack_slow = 1;
        send_pkt(188);
        send_pkt(188);
        drain("slow_ack");
        ack_slow = 0;

        // Asynchronous reset in the middle of a fill.
        send_pkt(100);
        #2 reset_n = 1'b0;
        #1 chk("reset_midfill_outputs", 64'(outvec()), 64'(0));
        model_reset();
        repeat (2) @(negedge ext_clk);
        reset_n = 1'b1;
        @(negedge ext_clk);
        send_junk(20);
        send_pkt(188);
        send_pkt(188);
        drain("after_reset");

        chk("writes_left", 64'(wq.size()), 64'(0));
        chk("commits_left", 64'(cq.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
